// File: rtl/spi_pkg.sv
// Shared SPI link constants: mode 2 framing (CPOL=1, CPHA=0), idle line levels, slave FSM states.
package spi_pkg;

  localparam int unsigned SPI_CPOL = 1;
  localparam int unsigned SPI_CPHA = 0;

  localparam logic SCK_IDLE  = 1'b1;
  localparam logic CS_IDLE   = 1'b1;
  localparam logic MOSI_IDLE = 1'b0;
  localparam logic MISO_IDLE = 1'b0;

  typedef enum logic {
    IDLE,
    ACTIVE
  } spi_state_e;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser for an asynchronous SPI line, with single-cycle rise/fall strobes.
module spi_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic        RST_VAL     = 1'b1
) (
  input  logic sysclk,
  input  logic rst,
  input  logic d,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   last_q;

  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) begin
      sync_q <= {SYNC_STAGES{RST_VAL}};
      last_q <= RST_VAL;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d};
      last_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise = sync_q[SYNC_STAGES-1] & ~last_q;
  assign fall = ~sync_q[SYNC_STAGES-1] & last_q;

endmodule

// File: rtl/spi_slave.sv
// SPI slave, CPOL=1/CPHA=0, MSB first: oversamples SCK/CS/MOSI on sysclk, delivers received
// words with a valid pulse and returns spi_tx_data on MISO within the same frame.
module spi_slave
  import spi_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                  sysclk,
  input  logic                  rst,
  input  logic                  Sspi_sck,
  input  logic                  Sspi_cs,
  input  logic                  Sspi_mosi,
  output logic                  Sspi_miso,
  output logic                  Sspi_miso_oe,
  input  logic [DATA_WIDTH-1:0] spi_tx_data,
  output logic [DATA_WIDTH-1:0] spi_rx_data,
  output logic                  spi_rx_valid,
  output logic                  spi_busy,
  output logic                  spi_frame_err
);

  localparam int unsigned CW = $clog2(DATA_WIDTH);

  logic                   sck_rise, sck_fall, cs_rise, cs_fall;
  logic [SYNC_STAGES-1:0] mosi_q;
  logic                   mosi_sync;

  spi_state_e             state, state_n;
  logic [CW-1:0]          bit_cnt, bit_cnt_n;
  logic [DATA_WIDTH-1:0]  tx_shift, tx_shift_n;
  logic [DATA_WIDTH-1:0]  rx_shift, rx_shift_n;
  logic [DATA_WIDTH-1:0]  rx_data_n;
  logic                   reload_pend, reload_pend_n;
  logic                   miso_n, miso_oe_n, rx_valid_n, busy_n, frame_err_n;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(SCK_IDLE)) u_sck_sync (
    .sysclk (sysclk),
    .rst    (rst),
    .d      (Sspi_sck),
    .rise   (sck_rise),
    .fall   (sck_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(CS_IDLE)) u_cs_sync (
    .sysclk (sysclk),
    .rst    (rst),
    .d      (Sspi_cs),
    .rise   (cs_rise),
    .fall   (cs_fall)
  );

  assign mosi_sync = mosi_q[SYNC_STAGES-1];

  always_comb begin
    state_n       = state;
    bit_cnt_n     = bit_cnt;
    tx_shift_n    = tx_shift;
    rx_shift_n    = rx_shift;
    rx_data_n     = spi_rx_data;
    reload_pend_n = reload_pend;
    miso_n        = Sspi_miso;
    miso_oe_n     = Sspi_miso_oe;
    busy_n        = spi_busy;
    rx_valid_n    = 1'b0;
    frame_err_n   = 1'b0;

    unique case (state)
      IDLE: begin
        if (cs_fall) begin
          state_n       = ACTIVE;
          tx_shift_n    = spi_tx_data;
          miso_n        = spi_tx_data[DATA_WIDTH-1];
          miso_oe_n     = 1'b1;
          bit_cnt_n     = '0;
          rx_shift_n    = '0;
          reload_pend_n = 1'b0;
          busy_n        = 1'b1;
        end
      end

      ACTIVE: begin
        // CS release has priority over a coincident sample edge.
        if (cs_rise) begin
          state_n       = IDLE;
          miso_n        = MISO_IDLE;
          miso_oe_n     = 1'b0;
          busy_n        = 1'b0;
          frame_err_n   = (bit_cnt != '0);
          bit_cnt_n     = '0;
          reload_pend_n = 1'b0;
        end else begin
          if (sck_fall) begin
            rx_shift_n = {rx_shift[DATA_WIDTH-2:0], mosi_sync};
            if (bit_cnt == CW'(DATA_WIDTH - 1)) begin
              rx_data_n     = rx_shift_n;
              rx_valid_n    = 1'b1;
              bit_cnt_n     = '0;
              reload_pend_n = 1'b1;
            end else begin
              bit_cnt_n = bit_cnt + CW'(1);
            end
          end
          // The next-word reload is taken at the boundary shift edge rather than the last
          // sample edge, so user logic can answer the rx_valid pulse with a fresh tx word.
          if (sck_rise) begin
            if (reload_pend) begin
              tx_shift_n    = spi_tx_data;
              miso_n        = spi_tx_data[DATA_WIDTH-1];
              reload_pend_n = 1'b0;
            end else begin
              miso_n = tx_shift[CW'(DATA_WIDTH - 1) - bit_cnt];
            end
          end
        end
      end

      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      mosi_q        <= {SYNC_STAGES{MOSI_IDLE}};
      bit_cnt       <= '0;
      tx_shift      <= '0;
      rx_shift      <= '0;
      reload_pend   <= 1'b0;
      Sspi_miso     <= MISO_IDLE;
      Sspi_miso_oe  <= 1'b0;
      spi_rx_data   <= '0;
      spi_rx_valid  <= 1'b0;
      spi_busy      <= 1'b0;
      spi_frame_err <= 1'b0;
    end else begin
      state         <= state_n;
      mosi_q        <= {mosi_q[SYNC_STAGES-2:0], Sspi_mosi};
      bit_cnt       <= bit_cnt_n;
      tx_shift      <= tx_shift_n;
      rx_shift      <= rx_shift_n;
      reload_pend   <= reload_pend_n;
      Sspi_miso     <= miso_n;
      Sspi_miso_oe  <= miso_oe_n;
      spi_rx_data   <= rx_data_n;
      spi_rx_valid  <= rx_valid_n;
      spi_busy      <= busy_n;
      spi_frame_err <= frame_err_n;
    end
  end

endmodule
